dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128: data memory size in bytes; an access with addr + size_bytes > MEM_BYTES is out of range.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports mN_req_valid and mN_req_ready, for N = 0 and 1, each 1 bit: request handshake. valid is an input; ready is an output.
REQ-005 SHALL have port mN_req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port mN_req_size, input, 2: 01 = word, 10 = half, 11 = byte, 00 = illegal.
REQ-007 SHALL have port mN_req_sign, input, 1: sign-extend a load.
REQ-008 SHALL have ports mN_req_addr and mN_req_wdata, input, 32 each: byte address and store data.
REQ-009 SHALL have ports mN_resp_valid (output) and mN_resp_ready (input), 1 each: response handshake.
REQ-010 SHALL have ports mN_resp_rdata, output, 32, and mN_resp_err, output, 1.
REQ-011 SHALL have memory-side outputs mem_write_mem (2), mem_read_mem (3), mem_address (32) and mem_write_data (32), using the data-memory encodings: write 01/10/11 = word/half/byte; read[1:0] likewise and read[2] = signed; 00 = idle.
REQ-012 SHALL have port mem_out_mem, input, 32: combinational read data from the memory.

Function
REQ-013 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-014 In IDLE, when either req_valid is high, SHALL grant exactly one port and assert that port's req_ready combinationally in the same cycle; req_ready SHALL be 0 in every other state.
REQ-015 Arbitration SHALL be round-robin: a last-grant pointer starts at 1 after reset, so m0 wins the first tie; on a tie the port not granted last wins; a lone requester always wins.
REQ-016 On the accept edge, SHALL latch we, size, sign, addr, wdata and owner, then enter ACCESS.
REQ-017 In ACCESS, for a legal request, SHALL drive mem_* for exactly one cycle: a store drives mem_write_mem = size with mem_read_mem = 000; a load drives mem_read_mem = {sign, size} with mem_write_mem = 00. SHALL capture mem_out_mem into the response register on the ACCESS edge, then enter RESP.
REQ-018 Outside ACCESS, and in ACCESS for an illegal request, mem_write_mem and mem_read_mem SHALL be 00 and 000.
REQ-019 A request SHALL be illegal if size = 00, or it is out of range, or it is misaligned when checking is enabled (REQ-027). An illegal request SHALL cause no memory activity and SHALL produce err = 1 and rdata = 0.
REQ-020 In RESP, SHALL assert resp_valid to the owner only, with rdata and err stable, until resp_ready is high; on that edge SHALL return to IDLE.
REQ-021 Latency: accept at cycle N, memory access at N+1, resp_valid first high at N+2. With resp_ready tied high, one transaction SHALL take 3 cycles.
REQ-022 Store responses SHALL have rdata = 0 and err = 0.
REQ-023 A requester deasserting valid while not granted SHALL be legal and SHALL be ignored. A req_valid raised during ACCESS or RESP SHALL wait for IDLE.
REQ-024 SHALL allow only one transaction in flight; there SHALL be no request queueing.

Reset
REQ-025 While rst is high, SHALL asynchronously set: state = IDLE; last-grant pointer = 1; all req_ready, resp_valid and resp_err = 0; resp_rdata = 0; mem_write_mem = 00; mem_read_mem = 000; latched request = 0.
REQ-026 Reset asserted in ACCESS or RESP SHALL abort the transaction, issue no response, and leave no write strobe active after reset deasserts.

Configuration
REQ-027 Macro DMEM_ARB_ALIGN_CHK_EN: when defined, a word access with addr[1:0] != 0 and a half access with addr[0] != 0 SHALL be illegal (REQ-019). When not defined, alignment SHALL NOT be checked and such accesses SHALL reach the memory unchanged.

Verification
REQ-028 A bench SHALL cover: m0 stores word 0xDEADBEEF at 0x10, then m0 loads a signed byte at 0x13 -> mem_write_mem = 01 for one cycle, and the load returns rdata = 0xFFFFFFDE, err = 0, resp_valid at cycle N+2.
REQ-029 A bench SHALL cover: m0 and m1 valid together in IDLE for four back-to-back transactions -> grants m0, m1, m0, m1.
REQ-030 A bench SHALL cover: an m1 word load at 0x7E with MEM_BYTES = 128 -> err = 1, rdata = 0, mem_read_mem held at 000 throughout.
REQ-031 A bench SHALL cover: an m0 half load at 0x21 -> with DMEM_ARB_ALIGN_CHK_EN defined, err = 1 and no memory activity; without it, mem_read_mem = 010 and err = 0.
REQ-032 A bench SHALL cover: resp_ready held low for 5 cycles -> resp_valid, rdata and err stable, and a pending m1 request not granted until the cycle after the m0 handshake.
REQ-033 A bench SHALL cover: rst asserted mid-ACCESS of a store -> all outputs go to reset values immediately, and only the bytes written on a completed ACCESS edge change.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- request/response bundle between one requester and the
// data-memory arbiter.
//
// Signals:
//   req_valid   requester has a request pending
//   req_ready   arbiter accepts the request this cycle
//   req_we      1 = store, 0 = load
//   req_size    01 = word, 10 = half, 11 = byte, 00 = illegal
//   req_sign    sign-extend a load
//   req_addr    byte address
//   req_wdata   store data
//   resp_valid  response available to this requester
//   resp_ready  requester takes the response
//   resp_rdata  load data (0 for stores and errors)
//   resp_err    request was illegal
//
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port round-robin arbiter in front of a single data
// memory. One transaction in flight at a time, no queueing.
//
// Ports:
//   clk             single clock, all state on posedge
//   rst             asynchronous, active-high reset
//   m0, m1          requester ports (dmem_arbiter_if.slave)
//   mem_write_mem   store strobe/size: 01 word, 10 half, 11 byte, 00 idle
//   mem_read_mem    load strobe: [1:0] size as above, [2] signed, 000 idle
//   mem_address     byte address of the access
//   mem_write_data  store data
//   mem_out_mem     combinational read data from the memory
//
// Parameter:
//   MEM_BYTES       memory size in bytes; addr + size_bytes > MEM_BYTES is
//                   out of range
//
// Build option:
//   DMEM_ARB_ALIGN_CHK_EN  when defined, misaligned word/half accesses are
//                          rejected as illegal; otherwise they go to memory
//                          unchanged.
//
// state  | meaning
// IDLE   | waiting for a request; grants one port combinationally
// ACCESS | memory strobes active for one cycle, read data captured
// RESP   | response held to the owner until resp_ready
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [1:0]    mem_write_mem,
  output logic [2:0]    mem_read_mem,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_out_mem
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic        owner_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        illegal_q;
  logic [1:0]  mem_write_q;
  logic [2:0]  mem_read_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        any_valid;
  logic        grant_d;
  logic        accept;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sign;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        illegal_d;
  logic        owner_resp_ready;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b01:   return 3'd4;
      2'b10:   return 3'd2;
      2'b11:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Range check is done one bit wider so addresses near 2^32 cannot wrap
  // back into range.
  function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] end_addr;
    logic        bad;
    end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
    bad      = (size == 2'b00) || (end_addr > 33'(MEM_BYTES));
`ifdef DMEM_ARB_ALIGN_CHK_EN
    if ((size == 2'b01) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if ((size == 2'b10) && addr[0])              bad = 1'b1;
`endif
    return bad;
  endfunction

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    any_valid = m0.req_valid | m1.req_valid;
    grant_d   = 1'b0;
    if (m0.req_valid && m1.req_valid) begin
      grant_d = ~last_q;
    end else if (m1.req_valid) begin
      grant_d = 1'b1;
    end

    sel_we    = grant_d ? m1.req_we    : m0.req_we;
    sel_size  = grant_d ? m1.req_size  : m0.req_size;
    sel_sign  = grant_d ? m1.req_sign  : m0.req_sign;
    sel_addr  = grant_d ? m1.req_addr  : m0.req_addr;
    sel_wdata = grant_d ? m1.req_wdata : m0.req_wdata;
    illegal_d = is_illegal(sel_size, sel_addr);

    // rst is folded in so ready stays low while reset is held.
    accept = (state_q == ST_IDLE) && any_valid && !rst;

    owner_resp_ready = owner_q ? m1.resp_ready : m0.resp_ready;
  end

  assign m0.req_ready = accept & ~grant_d;
  assign m1.req_ready = accept &  grant_d;

  assign m0.resp_valid = resp_valid_q & ~owner_q;
  assign m1.resp_valid = resp_valid_q &  owner_q;
  assign m0.resp_rdata = owner_q ? 32'd0 : resp_rdata_q;
  assign m1.resp_rdata = owner_q ? resp_rdata_q : 32'd0;
  assign m0.resp_err   = resp_err_q & ~owner_q;
  assign m1.resp_err   = resp_err_q &  owner_q;

  assign mem_write_mem  = mem_write_q;
  assign mem_read_mem   = mem_read_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  // Memory strobes are registered on the accept edge so they are live for
  // exactly the ACCESS cycle and drop on the ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      illegal_q    <= 1'b0;
      mem_write_q  <= 2'b00;
      mem_read_q   <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q   <= grant_d;
            last_q    <= grant_d;
            we_q      <= sel_we;
            size_q    <= sel_size;
            sign_q    <= sel_sign;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            illegal_q <= illegal_d;
            if (!illegal_d) begin
              if (sel_we) begin
                mem_write_q <= sel_size;
              end else begin
                mem_read_q  <= {sel_sign, sel_size};
              end
            end
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          mem_write_q  <= 2'b00;
          mem_read_q   <= 3'b000;
          resp_valid_q <= 1'b1;
          resp_err_q   <= illegal_q;
          resp_rdata_q <= (illegal_q || we_q) ? 32'd0 : mem_out_mem;
          state_q      <= ST_RESP;
        end

        ST_RESP: begin
          if (owner_resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // size_q and sign_q are held for the whole transaction so the latched
  // request is complete; the strobes already carry them during ACCESS.
  logic unused_latched;
  assign unused_latched = ^{size_q, sign_q};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the arbiter and a
// byte-array reference memory.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 128;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fill_mem = 1'b0;
  logic [1:0]  mem_write_mem;
  logic [2:0]  mem_read_mem;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_out_mem;
  logic [31:0] dev_raw;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int ref_last;

  logic [7:0] dev_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_write_mem  (mem_write_mem),
    .mem_read_mem   (mem_read_mem),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_out_mem    (mem_out_mem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nbytes_of(input logic [1:0] s);
    case (s)
      2'b01:   return 4;
      2'b10:   return 2;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] seed_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Memory device: little-endian byte array, write on posedge, combinational
  // sign-extending read.
  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] <= seed_byte(i);
    end else if (mem_write_mem != 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes_of(mem_write_mem) && (longint'(mem_address) + i) < MEM_BYTES)
          dev_mem[mem_address[6:0] + 7'(i)] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    dev_raw = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < nbytes_of(mem_read_mem[1:0]) && (longint'(mem_address) + i) < MEM_BYTES)
        dev_raw[8*i +: 8] = dev_mem[mem_address[6:0] + 7'(i)];
    end
    mem_out_mem = dev_raw;
    if (mem_read_mem[2] && mem_read_mem[1:0] == 2'b11) mem_out_mem = {{24{dev_raw[7]}}, dev_raw[7:0]};
    if (mem_read_mem[2] && mem_read_mem[1:0] == 2'b10) mem_out_mem = {{16{dev_raw[15]}}, dev_raw[15:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: legality and result of one transaction from plain
  // arithmetic on the reference byte array.
  function automatic bit ref_illegal(input req_t r);
    int nb;
    nb = nbytes_of(r.size);
    if (nb == 0) return 1'b1;
    if (longint'(r.addr) + nb > MEM_BYTES) return 1'b1;
    if (ALIGN && (r.addr % nb) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_txn(input req_t r, output logic [31:0] rdata, output logic err);
    longint v;
    int nb;
    int base;
    nb = nbytes_of(r.size);
    rdata = 32'd0;
    err = 1'b0;
    if (ref_illegal(r)) begin
      err = 1'b1;
      return;
    end
    base = int'(r.addr);
    if (r.we) begin
      for (int i = 0; i < nb; i++) ref_mem[base + i] = 8'((r.wdata >> (8 * i)) & 32'hFF);
      return;
    end
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[base + i]) << (8 * i);
    if (r.sign && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    rdata = 32'(v);
  endtask

  task automatic drive_port(input int p, input bit v, input req_t r);
    if (p == 0) begin
      m0_if.req_valid = v;
      m0_if.req_we    = r.we;
      m0_if.req_size  = r.size;
      m0_if.req_sign  = r.sign;
      m0_if.req_addr  = r.addr;
      m0_if.req_wdata = r.wdata;
    end else begin
      m1_if.req_valid = v;
      m1_if.req_we    = r.we;
      m1_if.req_size  = r.size;
      m1_if.req_sign  = r.sign;
      m1_if.req_addr  = r.addr;
      m1_if.req_wdata = r.wdata;
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    int pick;
    r.we    = 1'($urandom_range(0, 1));
    r.sign  = 1'($urandom_range(0, 1));
    r.size  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    pick    = $urandom_range(0, 9);
    if (pick < 8)       r.addr = $urandom_range(0, MEM_BYTES - 1);
    else if (pick == 8) r.addr = $urandom_range(MEM_BYTES - 4, MEM_BYTES + 2);
    else                r.addr = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  // One full transaction starting in IDLE; the ungranted port's request is
  // left pending. hold = cycles resp_ready stays low in RESP.
  task automatic do_txn(input bit v0, input req_t r0, input bit v1, input req_t r1, input int hold,
                        output int grant, output logic [31:0] got_rdata, output logic got_err);
    int exp_grant;
    int t0;
    req_t r;
    bit bad;
    logic [31:0] exp_rd;
    logic exp_err;
    logic [1:0] exp_wr;
    logic [2:0] exp_rdm;
    t0 = cyc;
    got_rdata = 32'd0;
    got_err = 1'b0;
    drive_port(0, v0, r0);
    drive_port(1, v1, r1);
    m0_if.resp_ready = 1'b0;
    m1_if.resp_ready = 1'b0;
    exp_grant = (v0 && v1) ? ((ref_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    r = (exp_grant == 1) ? r1 : r0;
    bad = ref_illegal(r);
    ref_txn(r, exp_rd, exp_err);
    ref_last = exp_grant;
    #1;
    chk("idle_wr", 32'(mem_write_mem), 0);
    chk("idle_rd", 32'(mem_read_mem), 0);
    chk("ready_m0", 32'(m0_if.req_ready), 32'(exp_grant == 0));
    chk("ready_m1", 32'(m1_if.req_ready), 32'(exp_grant == 1));
    grant = m1_if.req_ready ? 1 : 0;

    @(posedge clk); #1;
    drive_port(exp_grant, 1'b0, r);
    if (exp_grant == 0) m1_if.resp_ready = 1'b1;
    else                m0_if.resp_ready = 1'b1;
    #1;
    exp_wr = 2'b00;
    exp_rdm = 3'b000;
    if (!bad) begin
      if (r.we) exp_wr = r.size;
      else      exp_rdm = {r.sign, r.size};
    end
    chk("acc_wr", 32'(mem_write_mem), 32'(exp_wr));
    chk("acc_rd", 32'(mem_read_mem), 32'(exp_rdm));
    if (!bad) chk("acc_addr", mem_address, r.addr);
    if (!bad && r.we) chk("acc_wdata", mem_write_data, r.wdata);
    chk("acc_rv", 32'({m1_if.resp_valid, m0_if.resp_valid}), 0);
    chk("acc_ready", 32'({m1_if.req_ready, m0_if.req_ready}), 0);

    @(posedge clk); #1;
    for (int c = 0; c <= hold; c++) begin
      if (c == hold) begin
        if (exp_grant == 0) m0_if.resp_ready = 1'b1;
        else                m1_if.resp_ready = 1'b1;
      end
      #1;
      got_rdata = (exp_grant == 1) ? m1_if.resp_rdata : m0_if.resp_rdata;
      got_err   = (exp_grant == 1) ? m1_if.resp_err : m0_if.resp_err;
      chk("resp_valid", 32'({m1_if.resp_valid, m0_if.resp_valid}), (exp_grant == 1) ? 2 : 1);
      chk("resp_rdata", got_rdata, exp_rd);
      chk("resp_err", 32'(got_err), 32'(exp_err));
      chk("resp_mem_idle", 32'({mem_write_mem, mem_read_mem}), 0);
      chk("resp_ready_low", 32'({m1_if.req_ready, m0_if.req_ready}), 0);
      @(posedge clk); #1;
    end
    m0_if.resp_ready = 1'b0;
    m1_if.resp_ready = 1'b0;
    chk("rv_drop", 32'({m1_if.resp_valid, m0_if.resp_valid}), 0);
    chk("txn_cycles", 32'(cyc - t0), 32'(3 + hold));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t rz;
    req_t ra;
    req_t rb;
    bit v0;
    bit v1;
    int g;
    logic [31:0] rd;
    logic er;
    int exp_rr [4];

    rz = '0;
    drive_port(0, 1'b0, rz);
    drive_port(1, 1'b0, rz);
    m0_if.resp_ready = 1'b0;
    m1_if.resp_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = seed_byte(i);
    ref_last = 1;

    // Reset values, with a request held to show ready is suppressed.
    #1;
    rst = 1'b1;
    fill_mem = 1'b1;
    drive_port(0, 1'b1, rz);
    @(posedge clk); #1;
    fill_mem = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr", 32'(mem_write_mem), 0);
    chk("rst_rd", 32'(mem_read_mem), 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_ready", 32'({m1_if.req_ready, m0_if.req_ready}), 0);
    chk("rst_rv", 32'({m1_if.resp_valid, m0_if.resp_valid}), 0);
    chk("rst_err", 32'({m1_if.resp_err, m0_if.resp_err}), 0);
    chk("rst_rdata", m0_if.resp_rdata, 0);
    drive_port(0, 1'b0, rz);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four back-to-back ties alternate starting from m0.
    exp_rr = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      ra = rand_req();
      rb = rand_req();
      do_txn(1'b1, ra, 1'b1, rb, 0, g, rd, er);
      chk("rr_tie", g, exp_rr[i]);
    end

    // Word store then signed byte load of its top byte.
    ra = '{we: 1'b1, size: 2'b01, sign: 1'b0, addr: 32'h10, wdata: 32'hDEADBEEF};
    do_txn(1'b1, ra, 1'b0, rz, 0, g, rd, er);
    ra = '{we: 1'b0, size: 2'b11, sign: 1'b1, addr: 32'h13, wdata: 32'h0};
    do_txn(1'b1, ra, 1'b0, rz, 0, g, rd, er);
    chk("sb_rdata", rd, 32'hFFFFFFDE);
    chk("sb_err", 32'(er), 0);

    // Word load straddling the top of memory.
    rb = '{we: 1'b0, size: 2'b01, sign: 1'b0, addr: 32'h7E, wdata: 32'h0};
    do_txn(1'b0, rz, 1'b1, rb, 0, g, rd, er);
    chk("oor_err", 32'(er), 1);
    chk("oor_rdata", rd, 0);

    // Misaligned half load.
    ra = '{we: 1'b0, size: 2'b10, sign: 1'b0, addr: 32'h21, wdata: 32'h0};
    do_txn(1'b1, ra, 1'b0, rz, 0, g, rd, er);
    chk("mis_err", 32'(er), ALIGN ? 1 : 0);

    // Make m1 the last winner, then hold m0's response with m1 pending.
    rb = '{we: 1'b1, size: 2'b11, sign: 1'b0, addr: 32'h50, wdata: 32'h000000A5};
    do_txn(1'b0, rz, 1'b1, rb, 0, g, rd, er);
    ra = '{we: 1'b0, size: 2'b01, sign: 1'b0, addr: 32'h10, wdata: 32'h0};
    rb = '{we: 1'b0, size: 2'b10, sign: 1'b1, addr: 32'h30, wdata: 32'h0};
    do_txn(1'b1, ra, 1'b1, rb, 5, g, rd, er);
    chk("hold_grant", g, 0);
    chk("hold_rdata", rd, 32'hDEADBEEF);
    do_txn(1'b0, rz, 1'b1, rb, 0, g, rd, er);
    chk("pend_grant", g, 1);

    // Reset in the middle of a store's ACCESS cycle.
    ra = '{we: 1'b1, size: 2'b01, sign: 1'b0, addr: 32'h40, wdata: 32'hCAFEF00D};
    drive_port(0, 1'b1, ra);
    #1;
    chk("ab_ready", 32'(m0_if.req_ready), 1);
    @(posedge clk); #1;
    drive_port(0, 1'b0, ra);
    rb = '{we: 1'b0, size: 2'b01, sign: 1'b0, addr: 32'h0, wdata: 32'h0};
    drive_port(1, 1'b1, rb);
    #1;
    chk("ab_acc_wr", 32'(mem_write_mem), 1);
    rst = 1'b1;
    #1;
    chk("ab_wr", 32'(mem_write_mem), 0);
    chk("ab_rd", 32'(mem_read_mem), 0);
    chk("ab_addr", mem_address, 0);
    chk("ab_wdata", mem_write_data, 0);
    chk("ab_ready0", 32'({m1_if.req_ready, m0_if.req_ready}), 0);
    chk("ab_rv", 32'({m1_if.resp_valid, m0_if.resp_valid}), 0);
    @(posedge clk); #1;
    chk("ab_hold_wr", 32'(mem_write_mem), 0);
    drive_port(1, 1'b0, rb);
    rst = 1'b0;
    ref_last = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ab_no_resp", 32'({m1_if.resp_valid, m0_if.resp_valid}), 0);
    for (int i = 0; i < 4; i++) chk("ab_mem", 32'(dev_mem[32'h40 + i]), 32'(ref_mem[32'h40 + i]));

    // Pointer is back at its reset value.
    ra = rand_req();
    rb = rand_req();
    do_txn(1'b1, ra, 1'b1, rb, 0, g, rd, er);
    chk("rr_after_rst", g, 0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) begin
        v0 = 1'b1;
        v1 = 1'b1;
      end
      ra = rand_req();
      rb = rand_req();
      do_txn(v0, ra, v1, rb, $urandom_range(0, 3), g, rd, er);
    end
    drive_port(0, 1'b0, rz);
    drive_port(1, 1'b0, rz);
    @(posedge clk); #1;

    for (int i = 0; i < MEM_BYTES; i++) chk("mem_final", 32'(dev_mem[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
